// File: rtl/cnn_relu_maxpool.sv
// ReLU + requantize (shift, unsigned saturate) + 2x2 stride-2 max pooling over a
// streamed raster conv-output map, CO channels in parallel.
module cnn_relu_maxpool #(
  parameter int CO     = 16,
  parameter int I_BW   = 20,
  parameter int O_BW   = 8,
  parameter int SHIFT  = 8,
  parameter int FMAP_W = 26,
  parameter int FMAP_H = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_soft_reset,
  input  logic                 i_in_valid,
  input  logic [CO*I_BW-1:0]   i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*O_BW-1:0]   o_ot_fmap,
  output logic                 o_frame_done
);

  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int LN = FMAP_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
  localparam logic [O_BW-1:0] Q_MAX = {O_BW{1'b1}};

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [CO*O_BW-1:0] q;
  logic [CO*O_BW-1:0] hold_reg;
  logic [CO*O_BW-1:0] h;
  logic [CO*O_BW-1:0] pooled;
  logic [CO*O_BW-1:0] lb_rd;
  logic [CO*O_BW-1:0] line_buf [LN];
  logic [LW-1:0]      lb_idx;
  logic               col_last;
  logic               row_last;

  assign col_last = (col == CW'(FMAP_W - 1));
  assign row_last = (row == RW'(FMAP_H - 1));
  assign lb_idx   = LW'(col >> 1);
  assign lb_rd    = line_buf[lb_idx];

  // Negative values clamp to zero; shifted positives above the output range saturate.
  always_comb begin
    logic [I_BW-1:0] x;
    logic [I_BW-1:0] s;
    q = '0;
    for (int c = 0; c < CO; c++) begin
      x = i_in_fmap[c*I_BW +: I_BW];
      s = x >> SHIFT;
      if (x[I_BW-1])
        q[c*O_BW +: O_BW] = '0;
      else if (|s[I_BW-1:O_BW])
        q[c*O_BW +: O_BW] = Q_MAX;
      else
        q[c*O_BW +: O_BW] = s[O_BW-1:0];
    end
  end

  always_comb begin
    h      = '0;
    pooled = '0;
    for (int c = 0; c < CO; c++) begin
      h[c*O_BW +: O_BW] = (hold_reg[c*O_BW +: O_BW] > q[c*O_BW +: O_BW]) ?
                          hold_reg[c*O_BW +: O_BW] : q[c*O_BW +: O_BW];
      pooled[c*O_BW +: O_BW] = (lb_rd[c*O_BW +: O_BW] > h[c*O_BW +: O_BW]) ?
                               lb_rd[c*O_BW +: O_BW] : h[c*O_BW +: O_BW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      hold_reg     <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else if (i_soft_reset) begin
      col          <= '0;
      row          <= '0;
      hold_reg     <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold_reg <= q;
        end else if (row[0]) begin
          o_ot_fmap    <= pooled;
          o_ot_valid   <= 1'b1;
          o_frame_done <= col_last && row_last;
        end
      end
    end
  end

  // Line buffer is never read before an even row has rewritten it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_in_valid && !i_soft_reset && col[0] && !row[0])
      line_buf[lb_idx] <= h;
  end

endmodule

// File: tb/tb_cnn_relu_maxpool.sv
// Scoreboard bench for cnn_relu_maxpool: 4x4 maps, one SHIFT=0 and one SHIFT=8 instance.
module tb_cnn_relu_maxpool;

  localparam int CO   = 4;
  localparam int I_BW = 20;
  localparam int O_BW = 8;

  typedef struct {
    logic [CO*O_BW-1:0] fmap;
    logic               done;
    longint             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic softReset = 1'b0;
  logic valid0 = 1'b0;
  logic valid8 = 1'b0;
  logic [CO*I_BW-1:0] fmap0 = '0;
  logic [CO*I_BW-1:0] fmap8 = '0;
  logic otValid0, otValid8, done0, done8;
  logic [CO*O_BW-1:0] otFmap0, otFmap8;

  exp_t q0[$];
  exp_t q8[$];
  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  int doneCount0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_relu_maxpool #(.CO(CO), .I_BW(I_BW), .O_BW(O_BW), .SHIFT(0), .FMAP_W(4), .FMAP_H(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(softReset), .i_in_valid(valid0),
    .i_in_fmap(fmap0), .o_ot_valid(otValid0), .o_ot_fmap(otFmap0), .o_frame_done(done0));

  cnn_relu_maxpool #(.CO(CO), .I_BW(I_BW), .O_BW(O_BW), .SHIFT(8), .FMAP_W(4), .FMAP_H(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .i_soft_reset(softReset), .i_in_valid(valid8),
    .i_in_fmap(fmap8), .o_ot_valid(otValid8), .o_ot_fmap(otFmap8), .o_frame_done(done8));

  function automatic logic [CO*I_BW-1:0] pack4(input int a, input int b, input int c, input int d);
    int v[4];
    logic [CO*I_BW-1:0] r;
    v = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < CO; i++) r[i*I_BW +: I_BW] = v[i][I_BW-1:0];
    return r;
  endfunction

  function automatic logic [CO*O_BW-1:0] packO(input int a, input int b, input int c, input int d);
    int v[4];
    logic [CO*O_BW-1:0] r;
    v = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < CO; i++) r[i*O_BW +: O_BW] = v[i][O_BW-1:0];
    return r;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input logic [CO*O_BW-1:0] actF, input logic actD,
                             input longint actC, input exp_t e);
    checkValue({name, " fmap"}, 64'(actF), 64'(e.fmap));
    checkValue({name, " frame_done"}, 64'(actD), 64'(e.done));
    checkValue({name, " latency cycle"}, 64'(actC), 64'(e.cyc));
  endtask

  // Drives one pixel into the selected instance and registers its expected pulse, if any.
  task automatic applyStimulus(input int sel, input logic [CO*I_BW-1:0] d, input bit hasExp,
                               input logic [CO*O_BW-1:0] ef, input bit ed);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin valid0 = 1'b1; fmap0 = d; end
    else begin valid8 = 1'b1; fmap8 = d; end
    if (hasExp) begin
      e.fmap = ef;
      e.done = ed;
      e.cyc  = cyc + 1;
      if (sel == 0) q0.push_back(e); else q8.push_back(e);
    end
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int winOf(input int k);
    return (k == 5) ? 0 : (k == 7) ? 1 : (k == 13) ? 2 : (k == 15) ? 3 : -1;
  endfunction

  // ch0 = base+1..base+16 raster, ch1 descending, ch2 zero, ch3 negative.
  task automatic runFrame(input int base, input int maxGap, input int nPix);
    int e0[4];
    int e1[4];
    int w;
    logic [CO*O_BW-1:0] ef;
    e0 = '{6, 8, 14, 16};
    e1 = '{16, 14, 8, 6};
    for (int k = 0; k < nPix; k++) begin
      w = winOf(k);
      ef = '0;
      if (w >= 0) ef = packO(base + e0[w], base + e1[w], 0, 0);
      applyStimulus(0, pack4(base + k + 1, base + 16 - k, 0, -1), w >= 0, ef, w == 3);
      if (maxGap > 0) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((q0.size() != 0 || q8.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkValue("scoreboard drained dut0", 64'(q0.size()), 64'd0);
    checkValue("scoreboard drained dut8", 64'(q8.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (otValid0) begin
      if (done0) doneCount0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut0 unexpected pulse: got fmap %0h, wanted no pulse", otFmap0);
      end else begin
        e = q0.pop_front();
        checkOutput("dut0", otFmap0, done0, cyc, e);
      end
    end else if (done0) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut0 frame_done without valid: got 1, wanted 0");
    end
    if (otValid8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut8 unexpected pulse: got fmap %0h, wanted no pulse", otFmap8);
      end else begin
        e = q8.pop_front();
        checkOutput("dut8", otFmap8, done8, cyc, e);
      end
    end else if (done8) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut8 frame_done without valid: got 1, wanted 0");
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation got no end, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0[16];
    int w;
    int doneBase;
    logic [CO*O_BW-1:0] ef8[4];

    // Async reset state
    repeat (2) @(negedge clk);
    checkValue("reset valid dut0", 64'(otValid0), 64'd0);
    checkValue("reset done dut0", 64'(done0), 64'd0);
    checkValue("reset fmap dut0", 64'(otFmap0), 64'd0);
    checkValue("reset fmap dut8", 64'(otFmap8), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Raster 1..16, back-to-back
    $display("[TB] basic frame");
    runFrame(0, 0, 16);
    waitDrain();

    // Requantization with SHIFT=8 and saturation
    $display("[TB] shift/saturation frame");
    s0 = '{-5, 300, 65535, 65536, 0, 0, 256, 255, 0, 0, 0, 0, 0, 0, 0, 0};
    ef8[0] = packO(1, 255, 0, 2);
    ef8[1] = packO(255, 255, 0, 2);
    ef8[2] = packO(0, 255, 0, 2);
    ef8[3] = packO(0, 255, 0, 2);
    for (int k = 0; k < 16; k++) begin
      w = winOf(k);
      applyStimulus(1, pack4(s0[k], 32'h7FFFF, -524288, 512), w >= 0,
                    (w >= 0) ? ef8[w[1:0]] : '0, w == 3);
    end
    waitDrain();

    // All-negative inputs
    $display("[TB] negative frame");
    for (int k = 0; k < 16; k++) begin
      w = winOf(k);
      applyStimulus(0, pack4(-(k*37 + 1), -(k*37 + 1001), -(k*37 + 2001), -(k*37 + 3001)),
                    w >= 0, '0, w == 3);
    end
    waitDrain();

    // Random idle gaps
    $display("[TB] gapped frame");
    runFrame(0, 3, 16);
    waitDrain();

    // Two seamless frames
    $display("[TB] back-to-back frames");
    doneBase = doneCount0;
    runFrame(0, 0, 16);
    runFrame(100, 0, 16);
    waitDrain();
    checkValue("frame_done pulses over two frames", 64'(doneCount0 - doneBase), 64'd2);

    // Soft reset after input #7; the same-cycle pixel #8 must be dropped
    $display("[TB] soft reset mid-frame");
    runFrame(0, 0, 7);
    @(negedge clk);
    softReset = 1'b1;
    valid0 = 1'b1;
    fmap0 = pack4(8, 9, 0, -1);
    @(posedge clk);
    #1;
    softReset = 1'b0;
    valid0 = 1'b0;
    @(negedge clk);
    checkValue("soft reset valid", 64'(otValid0), 64'd0);
    checkValue("soft reset fmap cleared", 64'(otFmap0), 64'd0);
    runFrame(0, 0, 16);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_relu_maxpool.md
Name: cnn_relu_maxpool

Overview:
- Downstream stage of cnn_core; consumes its per-pixel bias-added conv outputs (CO channels, raster order).
- Per channel: applies ReLU, requantizes by arithmetic right shift with unsigned saturation, then 2x2 stride-2 max pooling across the streamed conv-output map.
- Emits one pooled vector per 2x2 window to the next layer or the output buffer.

Parameters:
- CO, 16, output channels processed in parallel.
- I_BW, 20, input bit width per channel (signed two's complement, acc+bias).
- O_BW, 8, output bit width per channel (unsigned).
- SHIFT, 8, requantization right-shift amount, 0..I_BW-1.
- FMAP_W, 26, conv-output map width in pixels; even, >=2.
- FMAP_H, 26, conv-output map height in pixels; even, >=2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- i_soft_reset  input  1  synchronous clear, same effect as reset.
- i_in_valid  input  1  one conv-output pixel present on i_in_fmap.
- i_in_fmap  input  CO*I_BW  channel c at bits [c*I_BW +: I_BW], signed.
- o_ot_valid  output  1  one-cycle pulse per pooled pixel.
- o_ot_fmap  output  CO*O_BW  pooled channel c at [c*O_BW +: O_BW]; held between pulses.
- o_frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (async reset_n low or i_soft_reset high at clk edge):
  - o_ot_valid=0, o_frame_done=0, o_ot_fmap=0.
  - Column/row counters=0; horizontal hold register=0.
  - Line buffer contents are don't-care; they are always written before being read.
  - i_soft_reset takes priority over a same-cycle i_in_valid, which is dropped.
- No backpressure. Input accepted on every cycle with i_in_valid=1. Arbitrary gaps allowed; counters and state advance only on valid.
- Quantize (combinational, per channel): x<0 -> q=0; else s = x>>>SHIFT; s > 2^O_BW-1 -> q=2^O_BW-1; else q=s[O_BW-1:0].
- Counters: col 0..FMAP_W-1, row 0..FMAP_H-1.
  - On valid: col++; at col=FMAP_W-1, col wraps to 0 and row++.
  - At row=FMAP_H-1 and col=FMAP_W-1, both wrap to 0 and the next frame starts seamlessly.
- Horizontal stage, on valid:
  - col even: hold_reg <= q.
  - col odd: h = per-channel unsigned max(hold_reg, q), combinational.
- Vertical stage, col odd, on valid:
  - row even: line_buf[col>>1] <= h. FMAP_W/2 entries of CO*O_BW; register array or inferred RAM with combinational read.
  - row odd: o_ot_fmap <= per-channel max(line_buf[col>>1], h); o_ot_valid <= 1.
- Latency: o_ot_valid asserts exactly 1 cycle after the accepted (odd row, odd col) input. Deasserts the next cycle unless that cycle also completes a window; it cannot, because completing windows are at least 2 valid inputs apart.
- o_frame_done <= 1 in the same cycle as o_ot_valid when the completing input is (row=FMAP_H-1, col=FMAP_W-1).
- Output rate: (FMAP_W/2)*(FMAP_H/2) pulses per frame, in pooled raster order.
- Ties: equal values give that value; max is unsigned on quantized values.
- Reset mid-frame: partial windows are discarded and counting restarts at (0,0). No spurious o_ot_valid is produced from stale line_buf data.

Test Plan:
- FMAP_W=FMAP_H=4, SHIFT=0, O_BW=8, ch0 inputs 1..16 raster, back-to-back valid -> 4 pulses, ch0 = 6, 8, 14, 16; o_frame_done only with the 4th; each pulse 1 cycle after inputs #6, #8, #14, #16.
- Same, SHIFT=8, ch0 inputs: -5, 300, 65535, 65536 (row0), then 0, 0, 256, 255 (row1) -> window0 = max(0, 1, 0, 0) = 1; window1 = max(255, 255, 1, 0) = 255 (65536>>8=256 saturates to 255).
- All inputs negative on every channel -> every pooled output 0 on all CO channels.
- Same data as test 1 with random 0-3 idle cycles between valids -> identical output values; each pulse still exactly 1 cycle after its completing valid.
- Two frames back-to-back, second frame = first +100 -> frame-2 outputs 106, 108, 114, 116; two o_frame_done pulses total.
- i_soft_reset asserted after input #7 of frame 1, then a full fresh frame -> no output from the aborted frame; fresh frame yields 6, 8, 14, 16.
